// File: rtl/ysyx_25010008_lsu.sv
// Load/store unit: takes one memory request at a time and runs it over separate
// read (AR/R) and write (AW/W/B) bus channels, then returns one response.
// Misaligned accesses are rejected locally when MISALIGN_CHECK is set. Size 3 is
// always rejected locally.
module ysyx_25010008_lsu #(
  parameter int unsigned MISALIGN_CHECK = 1
) (
  input  logic        clock,
  input  logic        reset,
  // Request channel
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [4:0]  req_rd,
  // Response channel
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        resp_err,
  // Bus read channels
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  // Bus write channels
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  output logic        bready,
  input  logic [1:0]  bresp,
  input  logic        bvalid
);

  typedef enum logic [2:0] {
    StIdle,
    StAr,
    StR,
    StAww,
    StB,
    StResp
  } state_e;

  state_e      state_q;
  logic        wen_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [4:0]  rd_q;
  logic        err_q;
  logic        aw_done_q;
  logic        w_done_q;

  logic        req_fire;
  logic        req_misaligned;
  logic        req_illegal;
  logic        aw_done_d;
  logic        w_done_d;
  logic [31:0] load_shifted;
  logic [31:0] load_data;

  assign req_fire       = req_valid & req_ready;
  assign req_misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                          ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
  // Size 3 has no bus encoding here, so it is rejected even with checking off.
  assign req_illegal    = (req_size == 2'd3) || ((MISALIGN_CHECK != 0) && req_misaligned);

  // AW and W complete independently; each flag sticks until both are done.
  assign aw_done_d = aw_done_q | (awvalid & awready);
  assign w_done_d  = w_done_q  | (wvalid & wready);

  // Sequencer: request latching, bus phases and response capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      size_q     <= '0;
      unsigned_q <= 1'b0;
      rd_q       <= '0;
      err_q      <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_fire) begin
            wen_q      <= req_wen;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            rd_q       <= req_rd;
            // Cleared so rejected and store responses carry zero data.
            rdata_q    <= '0;
            err_q      <= req_illegal;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            if (req_illegal) begin
              state_q <= StResp;
            end else if (req_wen) begin
              state_q <= StAww;
            end else begin
              state_q <= StAr;
            end
          end
        end
        StAr: begin
          if (arready) begin
            state_q <= StR;
          end
        end
        StR: begin
          if (rvalid) begin
            rdata_q <= rdata;
            err_q   <= (rresp != 2'b00);
            state_q <= StResp;
          end
        end
        StAww: begin
          if (aw_done_d && w_done_d) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            state_q   <= StB;
          end else begin
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
          end
        end
        StB: begin
          if (bvalid) begin
            err_q   <= (bresp != 2'b00);
            state_q <= StResp;
          end
        end
        StResp: begin
          if (resp_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Handshake outputs decoded purely from state and completion flags.
  always_comb begin
    req_ready  = (state_q == StIdle);
    arvalid    = (state_q == StAr);
    rready     = (state_q == StR);
    awvalid    = (state_q == StAww) && !aw_done_q;
    wvalid     = (state_q == StAww) && !w_done_q;
    bready     = (state_q == StB);
    resp_valid = (state_q == StResp);
  end

  assign araddr  = addr_q;
  assign awaddr  = addr_q;
  assign arsize  = {1'b0, size_q};
  assign awsize  = {1'b0, size_q};
  assign wdata   = wdata_q << {addr_q[1:0], 3'b000};
  assign resp_rd = rd_q;
  assign resp_err = err_q;

  // Byte-lane strobes follow the low address bits of the access.
  always_comb begin
    wstrb = 4'b1111;
    unique case (size_q)
      2'd0:    wstrb = 4'b0001 << addr_q[1:0];
      2'd1:    wstrb = 4'b0011 << addr_q[1:0];
      default: wstrb = 4'b1111;
    endcase
  end

  // Load data: move the addressed lane to bit 0, then extend to 32 bits.
  always_comb begin
    load_shifted = rdata_q >> {addr_q[1:0], 3'b000};
    load_data    = load_shifted;
    unique case (size_q)
      2'd0:    load_data = {{24{~unsigned_q & load_shifted[7]}}, load_shifted[7:0]};
      2'd1:    load_data = {{16{~unsigned_q & load_shifted[15]}}, load_shifted[15:0]};
      default: load_data = load_shifted;
    endcase
    resp_rdata = wen_q ? 32'h0 : load_data;
  end

endmodule

// File: tb/tb_ysyx_25010008_lsu.sv
// Testbench for ysyx_25010008_lsu: directed vector table, randomized traffic against
// a behavioural model, and a reset-in-flight sequence. The bench acts as bus slave.
module tb_ysyx_25010008_lsu;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic [4:0]  req_rd;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [2:0]  arsize, awsize;
  logic        arvalid, arready, rready, rvalid;
  logic [1:0]  rresp, bresp;
  logic        awvalid, awready, wvalid, wready, bready, bvalid;
  logic [3:0]  wstrb;

  always #5 clock = ~clock;

  ysyx_25010008_lsu #(.MISALIGN_CHECK(1)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_rd(resp_rd), .resp_err(resp_err),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rready(rready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bready(bready), .bresp(bresp), .bvalid(bvalid)
  );

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [4:0]  rd;
    logic [31:0] bdata;      // data the slave returns on R
    logic [1:0]  bresp;      // rresp or bresp the slave returns
    int          a_dly;      // valid cycles before arready/awready
    int          w_dly;      // valid cycles before wready
    int          d_dly;      // ready cycles before rvalid/bvalid
    int          hold;       // cycles resp_ready stays low
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic        exp_bus;
    int          exp_lat;    // 0 = not checked
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s.%s: got 0x%08h expected 0x%08h", tag, name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [1:0] size, input logic uns, input logic [4:0] rd,
                              input logic [31:0] bdata, input logic [1:0] br, input int a_dly,
                              input int w_dly, input int d_dly, input int hold,
                              input logic [31:0] erd, input logic eerr,
                              input logic [31:0] ewd, input logic [3:0] estrb,
                              input logic ebus, input int elat);
    vec_t v;
    v.wen = wen; v.addr = addr; v.wdata = wd; v.size = size; v.uns = uns; v.rd = rd;
    v.bdata = bdata; v.bresp = br; v.a_dly = a_dly; v.w_dly = w_dly; v.d_dly = d_dly;
    v.hold = hold; v.exp_rdata = erd; v.exp_err = eerr; v.exp_wdata = ewd;
    v.exp_wstrb = estrb; v.exp_bus = ebus; v.exp_lat = elat;
    return v;
  endfunction

  // Reference model: expected response from the access rules, in plain arithmetic.
  function automatic vec_t model(input vec_t v);
    vec_t        m;
    int unsigned off;
    logic        mis;
    logic [31:0] sh;
    logic [31:0] strb;
    m = v;
    off = 32'(v.addr[1:0]);
    mis = (v.size == 2'd1 && (v.addr % 2) != 0) || (v.size == 2'd2 && (v.addr % 4) != 0);
    m.exp_wdata = 0;
    m.exp_wstrb = 0;
    if (v.size == 2'd3 || mis) begin
      m.exp_rdata = 0; m.exp_err = 1'b1; m.exp_bus = 1'b0; m.exp_lat = 1;
    end else begin
      m.exp_bus = 1'b1;
      m.exp_err = (v.bresp != 0);
      m.exp_lat = (v.a_dly == 0 && v.w_dly == 0 && v.d_dly == 0) ? 3 : 0;
      if (v.wen) begin
        m.exp_rdata = 0;
        m.exp_wdata = v.wdata << (8 * off);
        if (v.size == 2'd0)      strb = 32'd1 << off;
        else if (v.size == 2'd1) strb = 32'd3 << off;
        else                     strb = 32'hF;
        m.exp_wstrb = strb[3:0];
      end else begin
        sh = v.bdata >> (8 * off);
        if (v.size == 2'd0) begin
          sh = sh % 256;
          if (!v.uns && sh >= 128) sh = sh - 256;
        end else if (v.size == 2'd1) begin
          sh = sh % 65536;
          if (!v.uns && sh >= 32768) sh = sh - 65536;
        end
        m.exp_rdata = sh;
      end
    end
    return m;
  endfunction

  task automatic bus_idle();
    arready = 0; rvalid = 0; rdata = $urandom; rresp = 2'd3;
    awready = 0; wready = 0; bvalid = 0; bresp = 2'd3; resp_ready = 0;
  endtask

  // Issue one request, play the slave with the vector's delays, check the response.
  task automatic run_txn(input vec_t v, input string tag);
    int cyc, ar_cnt, aw_cnt, w_cnt, d_cnt, hold_cnt, lat;
    int bad_addr, bad_hs, bad_stable, bad_drop;
    bit ar_done, aw_done, w_done, seen_resp, bus_seen, finished, rr_prev;
    logic [31:0] got_rdata, got_wdata;
    logic [3:0]  got_wstrb;
    logic        got_err;
    logic [4:0]  got_rd;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; d_cnt = 0; hold_cnt = 0; lat = 0;
    bad_addr = 0; bad_hs = 0; bad_stable = 0; bad_drop = 0;
    ar_done = 0; aw_done = 0; w_done = 0; seen_resp = 0; bus_seen = 0; finished = 0;
    rr_prev = 0; got_rdata = 0; got_wdata = 0; got_wstrb = 0; got_err = 0; got_rd = 0;

    @(negedge clock);
    chk(tag, "req_ready_idle", req_ready, 1);
    req_valid = 1; req_wen = v.wen; req_addr = v.addr; req_wdata = v.wdata;
    req_size = v.size; req_unsigned = v.uns; req_rd = v.rd;
    @(negedge clock);
    req_valid = 0; req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
    req_wen = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);

    for (cyc = 1; cyc <= 80 && !finished; cyc++) begin
      bus_idle();
      if (arvalid || awvalid || wvalid) bus_seen = 1;
      if (arvalid) begin
        if (ar_done || rready) bad_hs++;
        if (araddr !== v.addr || arsize !== {1'b0, v.size}) bad_addr++;
        rvalid = 1;  // stray rvalid outside R must be ignored
        if (ar_cnt >= v.a_dly) begin arready = 1; ar_done = 1; end
        ar_cnt++;
      end
      if (rready) begin
        if (bready) bad_hs++;
        if (d_cnt >= v.d_dly) begin rvalid = 1; rdata = v.bdata; rresp = v.bresp; end
        d_cnt++;
      end
      if (awvalid) begin
        if (aw_done) bad_hs++;
        if (awaddr !== v.addr || awsize !== {1'b0, v.size}) bad_addr++;
        bvalid = 1;  // stray bvalid outside B must be ignored
        if (aw_cnt >= v.a_dly) begin awready = 1; aw_done = 1; end
        aw_cnt++;
      end
      if (wvalid) begin
        if (w_done) bad_hs++;
        got_wdata = wdata; got_wstrb = wstrb;
        if (w_cnt >= v.w_dly) begin wready = 1; w_done = 1; end
        w_cnt++;
      end
      if (bready) begin
        if (awvalid || wvalid) bad_hs++;
        if (d_cnt >= v.d_dly) begin bvalid = 1; bresp = v.bresp; end
        d_cnt++;
      end
      if (resp_valid) begin
        if (rready || bready || arvalid || awvalid || wvalid) bad_hs++;
        if (rr_prev) begin
          bad_drop++;
          finished = 1;
        end else if (!seen_resp) begin
          seen_resp = 1; lat = cyc;
          got_rdata = resp_rdata; got_err = resp_err; got_rd = resp_rd;
        end else if (resp_rdata !== got_rdata || resp_err !== got_err || resp_rd !== got_rd) begin
          bad_stable++;
        end
        if (req_ready) bad_stable++;
        if (hold_cnt >= v.hold) resp_ready = 1;
        hold_cnt++;
      end else if (seen_resp) begin
        finished = 1;
      end
      rr_prev = resp_valid && resp_ready;
      if (!finished) @(negedge clock);
    end
    bus_idle();

    if (!finished) begin
      chk(tag, "timeout", 1, 0);
      reset = 1;
      @(negedge clock);
      reset = 0;
    end else begin
      chk(tag, "resp_rdata", got_rdata, v.exp_rdata);
      chk(tag, "resp_err", got_err, v.exp_err);
      chk(tag, "resp_rd", got_rd, v.rd);
      chk(tag, "bus_traffic", bus_seen, v.exp_bus);
      chk(tag, "bus_addr_size", bad_addr, 0);
      chk(tag, "handshake", bad_hs, 0);
      chk(tag, "resp_stable", bad_stable, 0);
      chk(tag, "resp_single", bad_drop, 0);
      chk(tag, "idle_after", req_ready, 1);
      if (v.wen && v.exp_bus) begin
        chk(tag, "wdata", got_wdata, v.exp_wdata);
        chk(tag, "wstrb", got_wstrb, v.exp_wstrb);
      end
      if (v.exp_lat != 0) chk(tag, "latency", lat, v.exp_lat);
    end
  endtask

  vec_t vecs[12];
  vec_t rv;

  initial begin
    int bad;
    bit hit;
    reset = 1; req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0; req_size = 0;
    req_unsigned = 0; req_rd = 0;
    bus_idle();

    //         wen addr          wdata         sz uns rd  bdata         br  a  w  d  h
    //         exp_rdata      err exp_wdata     strb    bus lat
    vecs[0]  = mk(0, 32'h8000_0003, 32'h0,         0, 0, 5,  32'h8012_3456, 0, 0, 0, 0, 0,
                  32'hFFFF_FF80, 0, 32'h0,         4'h0, 1, 3);
    vecs[1]  = mk(1, 32'h8000_0002, 32'h0000_ABCD, 1, 0, 6,  32'h0,         0, 0, 1, 0, 0,
                  32'h0,         0, 32'hABCD_0000, 4'hC, 1, 0);
    vecs[2]  = mk(0, 32'h0200_0048, 32'h0,         2, 0, 17, 32'hDEAD_BEEF, 0, 3, 0, 2, 0,
                  32'hDEAD_BEEF, 0, 32'h0,         4'h0, 1, 0);
    vecs[3]  = mk(0, 32'h8000_0001, 32'h0,         1, 0, 3,  32'hFFFF_FFFF, 0, 0, 0, 0, 0,
                  32'h0,         1, 32'h0,         4'h0, 0, 1);
    vecs[4]  = mk(0, 32'h0000_0100, 32'h0,         2, 0, 9,  32'h1234_5678, 2, 0, 0, 0, 5,
                  32'h1234_5678, 1, 32'h0,         4'h0, 1, 3);
    vecs[5]  = mk(1, 32'h0000_0010, 32'h1122_3344, 2, 0, 1,  32'h0,         0, 0, 0, 0, 0,
                  32'h0,         0, 32'h1122_3344, 4'hF, 1, 3);
    vecs[6]  = mk(0, 32'h0000_0081, 32'h0,         0, 1, 2,  32'h0000_F000, 0, 1, 0, 1, 0,
                  32'h0000_00F0, 0, 32'h0,         4'h0, 1, 0);
    vecs[7]  = mk(0, 32'h0000_0082, 32'h0,         1, 0, 4,  32'h9ABC_0000, 0, 0, 0, 0, 1,
                  32'hFFFF_9ABC, 0, 32'h0,         4'h0, 1, 3);
    vecs[8]  = mk(0, 32'h0000_0040, 32'h0,         3, 0, 7,  32'h5555_5555, 0, 0, 0, 0, 0,
                  32'h0,         1, 32'h0,         4'h0, 0, 1);
    vecs[9]  = mk(1, 32'h0000_0013, 32'h0000_00A5, 0, 0, 8,  32'h0,         1, 2, 0, 1, 0,
                  32'h0,         1, 32'hA500_0000, 4'h8, 1, 0);
    vecs[10] = mk(1, 32'h0000_0203, 32'hFFFF_FFFF, 1, 0, 10, 32'h0,         0, 0, 0, 0, 2,
                  32'h0,         1, 32'h0,         4'h0, 0, 1);
    vecs[11] = mk(0, 32'h0000_0002, 32'h0,         1, 1, 11, 32'h8001_0000, 0, 0, 0, 0, 0,
                  32'h0000_8001, 0, 32'h0,         4'h0, 1, 3);

    // Reset state
    @(negedge clock);
    @(negedge clock);
    reset = 0;
    chk("reset", "req_ready", req_ready, 1);
    chk("reset", "valids", {arvalid, rready, awvalid, wvalid, bready, resp_valid}, 0);
    chk("reset", "resp_fields", {resp_rdata, resp_rd, resp_err}, 0);

    foreach (vecs[i]) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset while waiting in R: transaction abandoned, no response.
    @(negedge clock);
    req_valid = 1; req_wen = 0; req_addr = 32'h0000_0300; req_size = 2; req_rd = 5'd9;
    @(negedge clock);
    req_valid = 0;
    hit = 0;
    for (int c = 0; c < 10 && !hit; c++) begin
      bus_idle();
      if (arvalid) arready = 1;
      if (rready) begin
        hit = 1;
        reset = 1;
      end
      @(negedge clock);
    end
    reset = 0;
    chk("rst_in_r", "reached_r", hit, 1);
    chk("rst_in_r", "req_ready", req_ready, 1);
    chk("rst_in_r", "valids", {arvalid, rready, awvalid, wvalid, bready, resp_valid}, 0);
    chk("rst_in_r", "resp_rd_cleared", resp_rd, 0);
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      rvalid = 1; rdata = $urandom; rresp = 0;
      @(negedge clock);
      if (resp_valid || !req_ready) bad++;
    end
    bus_idle();
    chk("rst_in_r", "no_response", bad, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 60; n++) begin
      rv.wen = 1'($urandom_range(0, 1));
      rv.size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      rv.addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (rv.size == 2'd1) rv.addr[0] = 1'b0;
        if (rv.size == 2'd2) rv.addr[1:0] = 2'b00;
      end
      rv.wdata = $urandom;
      rv.uns = 1'($urandom_range(0, 1));
      rv.rd = 5'($urandom);
      rv.bdata = $urandom;
      rv.bresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      if ($urandom_range(0, 3) == 0) begin
        rv.a_dly = 0; rv.w_dly = 0; rv.d_dly = 0;
      end else begin
        rv.a_dly = $urandom_range(0, 2);
        rv.w_dly = $urandom_range(0, 2);
        rv.d_dly = $urandom_range(0, 2);
      end
      rv.hold = $urandom_range(0, 2);
      rv = model(rv);
      run_txn(rv, $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_25010008_lsu.md
YSYX_25010008_LSU -- requirements
Module: ysyx_25010008_LSU

Interface
REQ-001 SHALL have parameter MISALIGN_CHECK, default 1; 1 = misaligned access returns error with no bus traffic, 0 = issue as-is.
REQ-002 SHALL have ports: clock in 1, system clock; reset in 1, synchronous, active-high.
REQ-003 SHALL have ports: req_valid in 1; req_ready out 1; req_wen in 1 (1=store); req_addr in 32; req_wdata in 32; req_size in 2 (0 byte, 1 half, 2 word); req_unsigned in 1 (zero-extend load); req_rd in 5 (destination tag).
REQ-004 SHALL have ports: resp_valid out 1; resp_ready in 1; resp_rdata out 32; resp_rd out 5; resp_err out 1.
REQ-005 SHALL have bus read ports: araddr out 32, arsize out 3, arvalid out 1, arready in 1, rready out 1, rdata in 32, rresp in 2, rvalid in 1.
REQ-006 SHALL have bus write ports: awaddr out 32, awsize out 3, awvalid out 1, awready in 1, wdata out 32, wstrb out 4, wvalid out 1, wready in 1, bready out 1, bresp in 2, bvalid in 1.

Function
REQ-007 SHALL implement states IDLE, AR, R, AWW, B, RESP; all handshake outputs decoded from state and flags only.
REQ-008 SHALL assert req_ready only in IDLE; on req_valid&req_ready latch wen, addr, wdata, size, unsigned, rd.
REQ-009 SHALL classify misaligned: size 1 with addr[0]=1; size 2 with addr[1:0]!=0; size 3 always illegal.
REQ-010 SHALL on accepted illegal/misaligned request (MISALIGN_CHECK=1, or size 3 regardless) go IDLE->RESP, resp_err=1, resp_rdata=0, no valid raised on bus.
REQ-011 SHALL on accepted load go IDLE->AR; arvalid=1 in AR, held with stable araddr/arsize until arready; then AR->R.
REQ-012 SHALL in R drive rready=1; on rvalid capture rdata, set err = (rresp!=0), go RESP.
REQ-013 SHALL drive araddr/awaddr = latched full byte address (no alignment masking); arsize=awsize={1'b0,size}.
REQ-014 SHALL on accepted store go IDLE->AWW, asserting awvalid and wvalid together; each deasserts after its own handshake (either order or same cycle); AWW->B when both done.
REQ-015 SHALL drive wdata = latched wdata << (8*addr[1:0]); wstrb = byte 4'b0001<<addr[1:0], half 4'b0011<<addr[1:0], word 4'b1111.
REQ-016 SHALL in B drive bready=1; on bvalid set err=(bresp!=0), resp_rdata=0, go RESP.
REQ-017 SHALL form load data: shift captured rdata right by 8*addr[1:0], take low 8/16/32 bits, sign-extend unless req_unsigned.
REQ-018 SHALL in RESP hold resp_valid=1 with stable resp_rdata/resp_rd/resp_err until resp_ready; then RESP->IDLE.
REQ-019 SHALL keep rready low outside R and bready low outside B; rvalid/bvalid in other states ignored.
REQ-020 SHALL have minimum load latency: accept cycle T, arvalid at T+1, resp_valid at T+3 with arready and rvalid same-cycle; store minimum likewise T+3.
REQ-021 SHALL not accept a new request until the RESP handshake completes (one outstanding access).

Reset
REQ-022 SHALL on reset go IDLE; arvalid, rready, awvalid, wvalid, bready, resp_valid = 0; latched addr/data/rd/err and rdata register = 0; req_ready=1 after reset deasserts.
REQ-023 SHALL on reset mid-transaction abandon it and be in IDLE the following cycle, no response produced.

Verification
REQ-024 Load byte signed addr 0x8000_0003, rdata 0x8012_3456, rresp 0 -> araddr 0x8000_0003, arsize 0, resp_rdata 0xFFFF_FF80, err 0.
REQ-025 Store half addr 0x8000_0002, wdata 0x0000_ABCD, awready one cycle before wready -> wdata 0xABCD_0000, wstrb 4'b1100, awvalid drops after its handshake, single response, err 0.
REQ-026 Load word addr 0x0200_0048, arready delayed 3 cycles, rvalid delayed 2 -> araddr stable throughout, resp_rdata = rdata, resp_rd = req_rd.
REQ-027 Load half addr 0x8000_0001, MISALIGN_CHECK=1 -> no arvalid, resp_valid next cycle with err 1, rdata 0.
REQ-028 resp_ready held low 5 cycles -> resp_valid/data stable, req_ready 0; rvalid with rresp 2 -> err 1.
REQ-029 Reset asserted while in R -> IDLE next cycle, all valids 0, no response emitted.
